// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry skid register slice; optional flush via PIPE_SKID_FLUSH_EN
module pipe_skid_reg #(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
`ifdef PIPE_SKID_FLUSH_EN
   input  logic             flush,
`endif
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy
);
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
   state_t           state, stateNext;
   logic [WIDTH-1:0] mainReg, skidReg;
   logic             doAccept, doRelease, flushNow;
`ifdef PIPE_SKID_FLUSH_EN
   assign flushNow = flush;
`else
   assign flushNow = 1'b0;
`endif
   assign doAccept  = in_valid & in_ready;
   assign doRelease = out_valid & out_ready;
   assign out_data  = mainReg;
   // state register
   always_ff @(posedge clk)
      state <= rst ? EMPTY : stateNext;
   // next state; flush empties the slice regardless of traffic
   always_comb
      stateNext = flushNow ? EMPTY :
                  (state == EMPTY) ? (doAccept ? ONE : EMPTY) :
                  (state == ONE)   ? ((doAccept & !doRelease) ? FULL :
                                      (!doAccept & doRelease) ? EMPTY : ONE) :
                  (doRelease ? ONE : FULL);
   // outputs are pure functions of state, so in_ready never sees out_ready
   always_comb begin
      out_valid = state != EMPTY;
      in_ready  = (state != FULL) & !flushNow;
      occupancy = state;
   end
   // MAIN loads fresh data when it becomes the head, or promotes SKID on a pop from FULL
   always_ff @(posedge clk)
      if (rst)
         mainReg <= RESET_VAL;
      else if (!flushNow)
         mainReg <= ((state == EMPTY) & doAccept) | ((state == ONE) & doAccept & doRelease) ? in_data :
                    ((state == FULL) & doRelease) ? skidReg : mainReg;
   // SKID catches the second word when the head cannot leave
   always_ff @(posedge clk)
      if (rst)
         skidReg <= RESET_VAL;
      else if (!flushNow && (state == ONE) && doAccept && !doRelease)
         skidReg <= in_data;
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: directed vector table plus flush and randomized FIFO-model checks
module tb_pipe_skid_reg;
   logic        clk = 0;
   logic        rst, inValid, outReady, flush32;
   logic [31:0] inData;
   logic        inReady, outValid;
   logic [31:0] outData;
   logic [1:0]  occ;
   logic        rst8, iv8, or8, flush8;
   logic [7:0]  id8, od8;
   logic        ir8, ov8;
   logic [1:0]  occ8;
   int          checks = 0, errors = 0;
   logic [7:0]  q[$];
   logic        mAcc, mRel;

   always #5 clk = ~clk;

   pipe_skid_reg dut (
      .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady), .in_data(inData),
      .out_valid(outValid), .out_ready(outReady),
`ifdef PIPE_SKID_FLUSH_EN
      .flush(flush32),
`endif
      .out_data(outData), .occupancy(occ)
   );

   pipe_skid_reg #(.WIDTH(8), .RESET_VAL(8'h5A)) dut8 (
      .clk(clk), .rst(rst8), .in_valid(iv8), .in_ready(ir8), .in_data(id8),
      .out_valid(ov8), .out_ready(or8),
`ifdef PIPE_SKID_FLUSH_EN
      .flush(flush8),
`endif
      .out_data(od8), .occupancy(occ8)
   );

   typedef struct {
      logic        r, iv;
      logic [31:0] d;
      logic        ordy, eov, eir;
      logic [31:0] eod;
      logic [1:0]  eocc;
   } vec_t;
   vec_t vt[18];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chkAll(input string tag, input logic eov, input logic eir, input logic [31:0] eod, input logic [1:0] eocc);
      chk({tag, " out_valid"}, {31'd0, outValid}, {31'd0, eov});
      chk({tag, " in_ready"}, {31'd0, inReady}, {31'd0, eir});
      chk({tag, " out_data"}, outData, eod);
      chk({tag, " occupancy"}, {30'd0, occ}, {30'd0, eocc});
   endtask

   task automatic drive(input logic r, input logic iv, input logic [31:0] d, input logic ordy);
      rst = r; inValid = iv; inData = d; outReady = ordy;
   endtask

   initial begin
      //        rst iv data          ordy  ov ir  out_data      occ
      vt[0]  = '{1, 1, 32'hDEADBEEF, 0,    0, 1, 32'h0,        0};
      vt[1]  = '{1, 1, 32'hDEADBEEF, 0,    0, 1, 32'h0,        0};
      vt[2]  = '{0, 1, 32'h1,        1,    1, 1, 32'h1,        1};
      vt[3]  = '{0, 1, 32'h2,        1,    1, 1, 32'h2,        1};
      vt[4]  = '{0, 1, 32'h3,        1,    1, 1, 32'h3,        1};
      vt[5]  = '{0, 0, 32'h0,        1,    0, 1, 32'h3,        0};
      vt[6]  = '{0, 1, 32'hA,        0,    1, 1, 32'hA,        1};
      vt[7]  = '{0, 1, 32'hB,        0,    1, 0, 32'hA,        2};
      vt[8]  = '{0, 1, 32'hC,        0,    1, 0, 32'hA,        2};
      vt[9]  = '{0, 1, 32'hC,        1,    1, 1, 32'hB,        1};
      vt[10] = '{0, 1, 32'hC,        1,    1, 1, 32'hC,        1};
      vt[11] = '{0, 0, 32'h0,        1,    0, 1, 32'hC,        0};
      vt[12] = '{0, 1, 32'h5,        0,    1, 1, 32'h5,        1};
      vt[13] = '{0, 1, 32'h6,        1,    1, 1, 32'h6,        1};
      vt[14] = '{0, 0, 32'h0,        0,    1, 1, 32'h6,        1};
      vt[15] = '{0, 1, 32'h7,        0,    1, 0, 32'h6,        2};
      vt[16] = '{1, 1, 32'h8,        1,    0, 1, 32'h0,        0};
      vt[17] = '{0, 0, 32'h0,        0,    0, 1, 32'h0,        0};
      flush32 = 0; flush8 = 0;
      rst8 = 1; iv8 = 0; or8 = 0; id8 = 0;
      drive(1, 0, 0, 0);
      for (int i = 0; i < 18; i++) begin
         drive(vt[i].r, vt[i].iv, vt[i].d, vt[i].ordy);
         @(posedge clk); #1;
         chkAll($sformatf("vec%0d", i), vt[i].eov, vt[i].eir, vt[i].eod, vt[i].eocc);
      end
`ifdef PIPE_SKID_FLUSH_EN
      drive(0, 1, 32'h7, 0); @(posedge clk); #1;
      drive(0, 1, 32'h8, 0); @(posedge clk); #1;
      chkAll("flush fill", 1, 0, 32'h7, 2);
      drive(0, 1, 32'h9, 0); flush32 = 1; #1;
      chk("flush in_ready", {31'd0, inReady}, 32'd0);
      @(posedge clk); #1;
      flush32 = 0;
      chk("flush out_valid", {31'd0, outValid}, 32'd0);
      chk("flush occupancy", {30'd0, occ}, 32'd0);
      drive(0, 0, 0, 1); @(posedge clk); #1;
      chkAll("post flush", 0, 1, 32'h7, 0);
      drive(0, 1, 32'hA, 1); @(posedge clk); #1;
      chkAll("post flush push", 1, 1, 32'hA, 1);
      drive(0, 0, 0, 1); @(posedge clk); #1;
      chkAll("post flush drain", 0, 1, 32'hA, 0);
`endif
      @(posedge clk); #1;
      rst8 = 0;
      chk("w8 reset out_data", {24'd0, od8}, 32'h5A);
      chk("w8 reset occupancy", {30'd0, occ8}, 32'd0);
      for (int c = 0; c < 1000; c++) begin
         iv8 = 1'($urandom_range(0, 1));
         or8 = 1'($urandom_range(0, 1));
         id8 = 8'($urandom_range(0, 255));
         #1;
         chk("w8 in_ready", {31'd0, ir8}, {31'd0, q.size() < 2});
         mAcc = iv8 & (q.size() < 2);
         mRel = (q.size() > 0) & or8;
         @(posedge clk); #1;
         if (mRel) void'(q.pop_front());
         if (mAcc) q.push_back(id8);
         chk("w8 out_valid", {31'd0, ov8}, {31'd0, q.size() > 0});
         chk("w8 occupancy", {30'd0, occ8}, q.size());
         if (q.size() > 0) chk("w8 out_data", {24'd0, od8}, {24'd0, q[0]});
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width in bits, legal range 1..256.
REQ-002 SHALL have parameter RESET_VAL, default {WIDTH{1'b0}}: value loaded into both storage registers on reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 SHALL have port in_valid  input  1  upstream has a word on in_data.
REQ-006 SHALL have port in_ready  output  1  block accepts a word this cycle.
REQ-007 SHALL have port in_data  input  WIDTH  upstream word.
REQ-008 SHALL have port out_valid  output  1  out_data holds a valid word.
REQ-009 SHALL have port out_ready  input  1  downstream takes the word this cycle.
REQ-010 SHALL have port out_data  output  WIDTH  oldest stored word.
REQ-011 SHALL have port occupancy  output  2  number of stored words, 0..2.
REQ-012 SHALL have port flush  input  1  discard all stored words; present only when PIPE_SKID_FLUSH_EN is defined.

Function
REQ-013 SHALL hold two registers, MAIN and SKID, and a state machine with states EMPTY, ONE and FULL.
REQ-014 SHALL define accept = in_valid & in_ready and release = out_valid & out_ready.
REQ-015 SHALL drive out_valid = (state != EMPTY), out_data = MAIN, and occupancy = 0/1/2 for EMPTY/ONE/FULL.
REQ-016 SHALL drive in_ready = (state != FULL), gated low by flush when flush is present; in_ready SHALL NOT depend combinationally on out_ready.
REQ-017 In state EMPTY, on accept: MAIN <= in_data and next state ONE; with no accept the state SHALL stay EMPTY.
REQ-018 In state ONE, on accept without release: SKID <= in_data and next state FULL.
REQ-019 In state ONE, on release without accept: next state EMPTY.
REQ-020 In state ONE, on accept and release in the same cycle: MAIN <= in_data and the state SHALL stay ONE.
REQ-021 In state FULL, on release: MAIN <= SKID and next state ONE; with no release the state SHALL stay FULL and both registers SHALL hold.
REQ-022 SHALL impose a latency of exactly 1 cycle from accept to out_valid when the block was EMPTY, and SHALL give a sustained throughput of 1 word/cycle while out_ready stays high.
REQ-023 SHALL deliver words in acceptance order, with no loss or duplication.
REQ-024 Registers not written in a cycle SHALL hold their values; stale register contents SHALL NOT be cleared.

Reset
REQ-025 When rst is high at a rising edge: state <= EMPTY and MAIN, SKID <= RESET_VAL; after that edge out_valid=0, in_ready=1, occupancy=0, out_data=RESET_VAL.
REQ-026 rst SHALL override accept, release and flush, and any stored words SHALL be discarded, including when reset occurs mid-transfer.

Configuration
REQ-027 With macro PIPE_SKID_FLUSH_EN defined, a high flush at a rising edge SHALL force next state EMPTY and drop both stored words, with no accept that cycle (in_ready=0); MAIN and SKID SHALL hold; release may still be observed downstream that cycle.
REQ-028 Without PIPE_SKID_FLUSH_EN, the flush port and all flush logic SHALL be absent, and behaviour SHALL equal REQ-013..REQ-026.

Verification
REQ-029 Reset: rst=1 for 2 cycles with in_valid=1, in_data=32'hDEADBEEF -> out_valid=0, in_ready=1, occupancy=0, out_data=0.
REQ-030 Streaming: out_ready=1, push 0x1,0x2,0x3 on consecutive cycles -> out_data 0x1,0x2,0x3 on the next three cycles; occupancy stays 1; in_ready stays 1.
REQ-031 Backpressure: out_ready=0, push 0xA then 0xB -> occupancy=2, in_ready=0, 0xC held off; raise out_ready -> outputs 0xA, 0xB, 0xC in order, no loss.
REQ-032 Simultaneous: state ONE holding 0x5, in_valid=1 with 0x6 and out_ready=1 -> next cycle out_data=0x6, occupancy=1.
REQ-033 Flush (PIPE_SKID_FLUSH_EN): FULL with 0x7,0x8, flush=1 with in_valid=1, in_data=0x9 -> next cycle occupancy=0, out_valid=0, 0x9 never emerges.
REQ-034 WIDTH=8, RESET_VAL=8'h5A: after reset out_data=8'h5A; a random push/pop run of 1000 cycles matches a reference FIFO model.
